// File: rtl/reg_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter_if
// Bundle of the two writeback request channels (A = ALU/execute, B = load/mem)
// and the registered register-file write port driven by reg_write_arbiter.
//
// Handshake (both channels): a transfer happens in a cycle where valid && ready.
// The requester holds valid/addr/data stable until it sees ready. Ready is a
// same-cycle combinational answer from the arbiter and is never high without
// valid.
//
// Signals:
//   a_valid_i/a_addr_i/a_data_i, a_ready_o   channel A request / grant
//   b_valid_i/b_addr_i/b_data_i, b_ready_o   channel B request / grant
//   RegWrite_o, w_addr_o, w_data_o           registered register-file write
// Modports: master = requester/register-file side, slave = arbiter.
// -----------------------------------------------------------------------------
interface reg_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid_i;
  logic [ADDR_W-1:0] a_addr_i;
  logic [DATA_W-1:0] a_data_i;
  logic              a_ready_o;
  logic              b_valid_i;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_data_i;
  logic              b_ready_o;
  logic              RegWrite_o;
  logic [ADDR_W-1:0] w_addr_o;
  logic [DATA_W-1:0] w_data_o;

  modport master (
    output a_valid_i, a_addr_i, a_data_i,
    output b_valid_i, b_addr_i, b_data_i,
    input  a_ready_o, b_ready_o,
    input  RegWrite_o, w_addr_o, w_data_o
  );

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i,
    input  b_valid_i, b_addr_i, b_data_i,
    output a_ready_o, b_ready_o,
    output RegWrite_o, w_addr_o, w_data_o
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Shares the single write port of the 32x32 register file between the ALU
// writeback (A) and the load writeback (B). At most one grant per cycle; the
// winning write is registered so the register file sees stable controls for a
// full cycle. Writes to r0 are granted but never committed. B cannot starve:
// in fixed-priority mode it is force-granted after AGE_LIMIT waiting cycles,
// in round-robin mode ties alternate.
//
// Ports:
//   clk_i, rst_i (async, active-high), stall_i (no grants while high)
//   bus     : reg_write_arbiter_if.slave (request channels + write port)
//   b_age_o : cycles B has been waiting (saturates at 15)
// Optional (macro WR_ARB_FWD_EN): r1/r2 read-port bypass of the committing
//   write: r1_addr_i, r2_addr_i, r1_rf_data_i, r2_rf_data_i, r1_data_o,
//   r2_data_o.
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int PRIO_MODE = 0,
  parameter int AGE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  reg_write_arbiter_if.slave  bus,
  output logic [3:0]          b_age_o
`ifdef WR_ARB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]   r1_addr_i,
  input  logic [ADDR_W-1:0]   r2_addr_i,
  input  logic [DATA_W-1:0]   r1_rf_data_i,
  input  logic [DATA_W-1:0]   r2_rf_data_i,
  output logic [DATA_W-1:0]   r1_data_o,
  output logic [DATA_W-1:0]   r2_data_o
`endif
);

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);

  grant_e            r_last_grant;
  grant_e            w_last_grant_nxt;
  logic [3:0]        r_age;
  logic [3:0]        w_age_nxt;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Grant decision. Gated by rst_i so ready drops the moment reset asserts.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!rst_i && !stall_i) begin
      if (bus.a_valid_i && bus.b_valid_i) begin
        if (PRIO_MODE == 1) begin
          if (r_last_grant == GNT_A) w_gnt_b = 1'b1;
          else                       w_gnt_a = 1'b1;
        end else if (r_age >= AGE_LIM) begin
          w_gnt_b = 1'b1;
        end else begin
          w_gnt_a = 1'b1;
        end
      end else if (bus.a_valid_i) begin
        w_gnt_a = 1'b1;
      end else if (bus.b_valid_i) begin
        w_gnt_b = 1'b1;
      end
    end
  end

  // Arbitration state: last winner and B wait count. Both freeze during stall.
  always_comb begin
    w_last_grant_nxt = r_last_grant;
    w_age_nxt        = r_age;
    if (w_gnt_a) w_last_grant_nxt = GNT_A;
    if (w_gnt_b) w_last_grant_nxt = GNT_B;
    if (!stall_i) begin
      if (bus.b_valid_i && !w_gnt_b) begin
        if (r_age != 4'hF) w_age_nxt = r_age + 4'd1;
      end else begin
        w_age_nxt = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= GNT_B;
      r_age        <= 4'd0;
    end else begin
      r_last_grant <= w_last_grant_nxt;
      r_age        <= w_age_nxt;
    end
  end

  // Registered write port. Address/data hold when nothing is granted; a grant
  // to r0 still loads them but leaves the enable low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_gnt_a) begin
        r_we   <= |bus.a_addr_i;
        r_addr <= bus.a_addr_i;
        r_data <= bus.a_data_i;
      end else if (w_gnt_b) begin
        r_we   <= |bus.b_addr_i;
        r_addr <= bus.b_addr_i;
        r_data <= bus.b_data_i;
      end
    end
  end

  assign bus.a_ready_o  = w_gnt_a;
  assign bus.b_ready_o  = w_gnt_b;
  assign bus.RegWrite_o = r_we;
  assign bus.w_addr_o   = r_addr;
  assign bus.w_data_o   = r_data;
  assign b_age_o        = r_age;

`ifdef WR_ARB_FWD_EN
  // The register file only samples on the falling edge, so reads in the
  // commit cycle see the committing value through this bypass.
  assign r1_data_o = (r_we && (r_addr == r1_addr_i) && (r1_addr_i != '0))
                     ? r_data : r1_rf_data_i;
  assign r2_data_o = (r_we && (r_addr == r2_addr_i) && (r2_addr_i != '0))
                     ? r_data : r2_rf_data_i;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
// Two arbiters side by side: inst 0 fixed priority with aging (AGE_LIMIT=4),
// inst 1 round-robin. Each has its own requesters and reference model.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic stall;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  reg_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  logic [3:0] age0, age1;

`ifdef WR_ARB_FWD_EN
  logic [AW-1:0] r1a, r2a;
  logic [DW-1:0] r1rf, r2rf;
  logic [DW-1:0] r1o [2];
  logic [DW-1:0] r2o [2];
`endif

  reg_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(0), .AGE_LIMIT(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bus(bus0), .b_age_o(age0)
`ifdef WR_ARB_FWD_EN
    , .r1_addr_i(r1a), .r2_addr_i(r2a), .r1_rf_data_i(r1rf), .r2_rf_data_i(r2rf),
    .r1_data_o(r1o[0]), .r2_data_o(r2o[0])
`endif
  );

  reg_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(1), .AGE_LIMIT(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bus(bus1), .b_age_o(age1)
`ifdef WR_ARB_FWD_EN
    , .r1_addr_i(r1a), .r2_addr_i(r2a), .r1_rf_data_i(r1rf), .r2_rf_data_i(r2rf),
    .r1_data_o(r1o[1]), .r2_data_o(r2o[1])
`endif
  );

  // ---------------- requester drive / observation ----------------
  logic          a_v [2];
  logic [AW-1:0] a_ad [2];
  logic [DW-1:0] a_dt [2];
  logic          b_v [2];
  logic [AW-1:0] b_ad [2];
  logic [DW-1:0] b_dt [2];

  assign bus0.a_valid_i = a_v[0];  assign bus1.a_valid_i = a_v[1];
  assign bus0.a_addr_i  = a_ad[0]; assign bus1.a_addr_i  = a_ad[1];
  assign bus0.a_data_i  = a_dt[0]; assign bus1.a_data_i  = a_dt[1];
  assign bus0.b_valid_i = b_v[0];  assign bus1.b_valid_i = b_v[1];
  assign bus0.b_addr_i  = b_ad[0]; assign bus1.b_addr_i  = b_ad[1];
  assign bus0.b_data_i  = b_dt[0]; assign bus1.b_data_i  = b_dt[1];

  logic          o_ar [2];
  logic          o_br [2];
  logic          o_we [2];
  logic [AW-1:0] o_wa [2];
  logic [DW-1:0] o_wd [2];
  logic [3:0]    o_age [2];

  assign o_ar[0] = bus0.a_ready_o;  assign o_ar[1] = bus1.a_ready_o;
  assign o_br[0] = bus0.b_ready_o;  assign o_br[1] = bus1.b_ready_o;
  assign o_we[0] = bus0.RegWrite_o; assign o_we[1] = bus1.RegWrite_o;
  assign o_wa[0] = bus0.w_addr_o;   assign o_wa[1] = bus1.w_addr_o;
  assign o_wd[0] = bus0.w_data_o;   assign o_wd[1] = bus1.w_data_o;
  assign o_age[0] = age0;           assign o_age[1] = age1;

  // ---------------- reference model ----------------
  bit            m_last_b [2];  // last winner was B
  int            m_age [2];
  bit            m_we [2];
  logic [AW-1:0] m_wa [2];
  logic [DW-1:0] m_wd [2];
  bit            g_a [2];
  bit            g_b [2];
  logic          seen_br [2];   // DUT b_ready sampled in the last cycle

  // Scoreboard of pending commits: {instance, addr, data}
  logic [AW+DW:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_last_b[i] = 1'b1;
      m_age[i]    = 0;
      m_we[i]     = 1'b0;
      m_wa[i]     = '0;
      m_wd[i]     = '0;
    end
    exp_q.delete();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) begin
      a_v[i] = 1'b0; a_ad[i] = '0; a_dt[i] = '0;
      b_v[i] = 1'b0; b_ad[i] = '0; b_dt[i] = '0;
    end
  endtask

  // Post new requests on idle ports with probability pct.
  task automatic refill(input int pct, input bit allow_zero);
    for (int i = 0; i < 2; i++) begin
      if (!a_v[i] && $urandom_range(0, 99) < pct) begin
        a_v[i]  = 1'b1;
        a_ad[i] = (allow_zero && $urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
        a_dt[i] = $urandom;
      end
      if (!b_v[i] && $urandom_range(0, 99) < pct) begin
        b_v[i]  = 1'b1;
        b_ad[i] = (allow_zero && $urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
        b_dt[i] = $urandom;
      end
    end
  endtask

  // One clock cycle. Entered just after a rising edge with inputs driven.
  task automatic run_cycle();
`ifdef WR_ARB_FWD_EN
    r1a  = ($urandom_range(0, 1) == 0) ? m_wa[$urandom_range(0, 1)] : AW'($urandom_range(0, 31));
    r2a  = ($urandom_range(0, 1) == 0) ? m_wa[$urandom_range(0, 1)] : AW'($urandom_range(0, 31));
    r1rf = $urandom;
    r2rf = $urandom;
`endif
    #1;
    for (int i = 0; i < 2; i++) begin
      // Who should win: lone requester wins; ties go by mode.
      g_a[i] = 1'b0;
      g_b[i] = 1'b0;
      if (!stall) begin
        if (a_v[i] && b_v[i]) begin
          if (i == 1) begin
            if (m_last_b[i]) g_a[i] = 1'b1; else g_b[i] = 1'b1;
          end else if (m_age[i] >= 4) g_b[i] = 1'b1;
          else g_a[i] = 1'b1;
        end else if (a_v[i]) g_a[i] = 1'b1;
        else if (b_v[i]) g_b[i] = 1'b1;
      end
      check($sformatf("i%0d_a_ready", i), 64'(o_ar[i]), 64'(g_a[i]));
      check($sformatf("i%0d_b_ready", i), 64'(o_br[i]), 64'(g_b[i]));
      seen_br[i] = o_br[i];
      if (g_a[i] && a_ad[i] != '0) exp_q.push_back({1'(i), a_ad[i], a_dt[i]});
      if (g_b[i] && b_ad[i] != '0) exp_q.push_back({1'(i), b_ad[i], b_dt[i]});
`ifdef WR_ARB_FWD_EN
      check($sformatf("i%0d_r1_fwd", i), 64'(r1o[i]),
            64'((m_we[i] && m_wa[i] == r1a && r1a != '0) ? m_wd[i] : r1rf));
      check($sformatf("i%0d_r2_fwd", i), 64'(r2o[i]),
            64'((m_we[i] && m_wa[i] == r2a && r2a != '0) ? m_wd[i] : r2rf));
`endif
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!stall) begin
        if (b_v[i] && !g_b[i]) m_age[i] = (m_age[i] >= 15) ? 15 : m_age[i] + 1;
        else m_age[i] = 0;
      end
      if (g_a[i]) begin
        m_we[i] = (a_ad[i] != '0); m_wa[i] = a_ad[i]; m_wd[i] = a_dt[i];
        m_last_b[i] = 1'b0; a_v[i] = 1'b0;
      end else if (g_b[i]) begin
        m_we[i] = (b_ad[i] != '0); m_wa[i] = b_ad[i]; m_wd[i] = b_dt[i];
        m_last_b[i] = 1'b1; b_v[i] = 1'b0;
      end else begin
        m_we[i] = 1'b0;
      end
      check($sformatf("i%0d_regwrite", i), 64'(o_we[i]), 64'(m_we[i]));
      check($sformatf("i%0d_w_addr", i), 64'(o_wa[i]), 64'(m_wa[i]));
      check($sformatf("i%0d_w_data", i), 64'(o_wd[i]), 64'(m_wd[i]));
      check($sformatf("i%0d_b_age", i), 64'(o_age[i]), 64'(m_age[i]));
      if (o_we[i]) begin
        if (exp_q.size() == 0) check($sformatf("i%0d_sb_unexpected", i), 64'(1), 64'(0));
        else check($sformatf("i%0d_sb_commit", i), 64'({1'(i), o_wa[i], o_wd[i]}),
                   64'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    clear_reqs();
    a_v[0] = 1'b1; a_v[1] = 1'b1; b_v[0] = 1'b1; b_v[1] = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("i%0d_rst_a_ready", i), 64'(o_ar[i]), 64'(0));
      check($sformatf("i%0d_rst_b_ready", i), 64'(o_br[i]), 64'(0));
      check($sformatf("i%0d_rst_regwrite", i), 64'(o_we[i]), 64'(0));
      check($sformatf("i%0d_rst_w_addr", i), 64'(o_wa[i]), 64'(0));
      check($sformatf("i%0d_rst_w_data", i), 64'(o_wd[i]), 64'(0));
      check($sformatf("i%0d_rst_b_age", i), 64'(o_age[i]), 64'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_reqs();
    model_reset();
  endtask

  // ---------------- main sequence ----------------
  logic [4:0] b_pat [2];

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    clear_reqs();
    model_reset();
`ifdef WR_ARB_FWD_EN
    r1a = '0; r2a = '0; r1rf = '0; r2rf = '0;
`endif
    @(posedge clk);
    #2;
    do_reset();

    // Tie from reset: round-robin alternates A,B,A,B; fixed priority gives
    // A four times, then B once its wait count reaches 4.
    b_pat[0] = '0; b_pat[1] = '0;
    for (int c = 0; c < 5; c++) begin
      refill(100, 1'b0);
      if (c == 4) check("i0_age_at_limit", 64'(o_age[0]), 64'(4));
      run_cycle();
      b_pat[0][c] = seen_br[0];
      b_pat[1][c] = seen_br[1];
    end
    check("i1_tie_rr_pattern", 64'(b_pat[1][3:0]), 64'(4'b1010));
    check("i0_aging_pattern", 64'(b_pat[0]), 64'(5'b10000));
    check("i0_age_after_force", 64'(o_age[0]), 64'(0));

    // Single A write.
    do_reset();
    a_v[0] = 1'b1; a_ad[0] = 5'd3; a_dt[0] = 32'h1234_5678;
    a_v[1] = 1'b1; a_ad[1] = 5'd3; a_dt[1] = 32'h1234_5678;
    run_cycle();
    check("single_a_we", 64'(o_we[0]), 64'(1));
    check("single_a_addr", 64'(o_wa[0]), 64'(3));
    check("single_a_data", 64'(o_wd[0]), 64'(32'h1234_5678));

    // Same address back to back: A then B to r5, last one wins.
    a_v[0] = 1'b1; a_ad[0] = 5'd5; a_dt[0] = 32'h0000_00AA;
    b_v[0] = 1'b1; b_ad[0] = 5'd5; b_dt[0] = 32'h0000_00BB;
    run_cycle();
    check("r5_first_data", 64'(o_wd[0]), 64'(32'hAA));
    run_cycle();
    check("r5_second_data", 64'(o_wd[0]), 64'(32'hBB));
    check("r5_second_we", 64'(o_we[0]), 64'(1));

    // Write to r0: handshake completes, no commit.
    clear_reqs();
    b_v[0] = 1'b1; b_ad[0] = '0; b_dt[0] = 32'hFFFF_FFFF;
    b_v[1] = 1'b1; b_ad[1] = '0; b_dt[1] = 32'hFFFF_FFFF;
    run_cycle();
    check("r0_b_ready", 64'(seen_br[0]), 64'(1));
    check("r0_no_write", 64'(o_we[0]), 64'(0));

    // Build age 1 on inst 0, then stall: no grants, age frozen.
    refill(100, 1'b0);
    run_cycle();
    refill(100, 1'b0);
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      run_cycle();
      check("stall_age_hold", 64'(o_age[0]), 64'(1));
      check("stall_no_write", 64'(o_we[0]), 64'(0));
    end
    stall = 1'b0;

`ifdef WR_ARB_FWD_EN
    clear_reqs();
    a_v[0] = 1'b1; a_ad[0] = 5'd7; a_dt[0] = 32'hCAFE_F00D;
    run_cycle();
    r1a = 5'd7; r1rf = '0;
    #1;
    check("fwd_r7_hit", 64'(r1o[0]), 64'(32'hCAFE_F00D));
    r1a = '0; r1rf = 32'h5555_AAAA;
    #1;
    check("fwd_r0_passthru", 64'(r1o[0]), 64'(32'h5555_AAAA));
`endif

    // Randomized traffic: heavy contention first, then lighter with stalls.
    for (int c = 0; c < 600; c++) begin
      refill((c < 300) ? 90 : 50, 1'b1);
      stall = ($urandom_range(0, 7) == 0);
      run_cycle();
    end
    stall = 1'b0;

    // Asynchronous reset while a write is being committed.
    clear_reqs();
    a_v[0] = 1'b1; a_ad[0] = 5'd9; a_dt[0] = $urandom;
    b_v[0] = 1'b1; b_ad[0] = 5'd10; b_dt[0] = $urandom;
    a_v[1] = 1'b1; a_ad[1] = 5'd9; a_dt[1] = $urandom;
    run_cycle();
    check("pre_rst_we", 64'(o_we[0]), 64'(1));
    check("pre_rst_age", 64'(o_age[0]), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_we", 64'(o_we[0]), 64'(0));
    check("mid_rst_age", 64'(o_age[0]), 64'(0));
    check("mid_rst_b_ready", 64'(o_br[0]), 64'(0));
    check("mid_rst_a_ready", 64'(o_ar[1]), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_reqs();
    model_reset();
    for (int c = 0; c < 40; c++) begin
      refill(70, 1'b1);
      run_cycle();
    end

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between two writeback requesters. Port A is the ALU/execute writeback; port B is the load/memory writeback. Grants at most one write per cycle and registers the winning write, so the register file sees stable write controls for a full cycle. Drops writes to register 0 and prevents starvation of the lower-priority requester.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
PRIO_MODE, 0, 0 = fixed priority A with aging for B; 1 = round-robin
AGE_LIMIT, 4, PRIO_MODE=0 only: consecutive cycles B may wait before it is force-granted (range 1..15)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
stall_i  in  1  freeze: no grants while high
a_valid_i  in  1  A write request
a_addr_i  in  ADDR_W  A destination register
a_data_i  in  DATA_W  A write data
a_ready_o  out  1  A granted this cycle (combinational)
b_valid_i  in  1  B write request
b_addr_i  in  ADDR_W  B destination register
b_data_i  in  DATA_W  B write data
b_ready_o  out  1  B granted this cycle (combinational)
RegWrite_o  out  1  register-file write enable (registered)
w_addr_o  out  ADDR_W  register-file write address (registered)
w_data_o  out  DATA_W  register-file write data (registered)
b_age_o  out  4  current B wait count (debug)

Behaviour:
- Reset (rst_i high, asynchronous): RegWrite_o=0, w_addr_o=0, w_data_o=0, b_age_o=0, last_grant=B; a_ready_o=b_ready_o=0 while rst_i is high.
- Handshake: a transfer occurs when valid && ready. The requester holds valid, addr and data stable until ready. Ready is never high without valid.
- Grant decision (combinational, rst_i=0, stall_i=0):
  - Only A valid -> grant A. Only B valid -> grant B. Neither valid -> no grant.
  - Both valid, PRIO_MODE=1 -> grant the port not in last_grant. After reset, A wins the first tie.
  - Both valid, PRIO_MODE=0 -> grant A, unless b_age_o >= AGE_LIMIT, in which case grant B.
- stall_i=1: no grant, both ready outputs 0, RegWrite_o loads 0 next edge; age counter holds.
- Commit: on the rising edge after a grant, RegWrite_o=1 and w_addr_o/w_data_o take the winner's addr/data. Latency is 1 cycle. The register file samples on the falling edge of the same cycle.
- Address 0: the grant and handshake complete normally, but RegWrite_o=0 next cycle. w_addr_o/w_data_o may update.
- No grant in a cycle -> RegWrite_o=0 next edge; w_addr_o/w_data_o hold.
- last_grant updates only on a grant.
- Age counter:
  - Increments when b_valid_i=1 and B is not granted (stall_i=0), saturating at 15.
  - Clears on a B grant or when b_valid_i=0.
  - Counts in PRIO_MODE=1 too, where it is informational only.
- Same-address back-to-back writes (A then B to r5): both commit in order on consecutive cycles; the last one wins.
- Reset mid-operation: any pending registered write is discarded (RegWrite_o forced 0 immediately) and arbitration state is cleared.

Optional Feature:
Macro WR_ARB_FWD_EN. When defined, adds these ports:
- r1_addr_i, r2_addr_i (in, ADDR_W)
- r1_rf_data_i, r2_rf_data_i (in, DATA_W): register-file read data
- r1_data_o, r2_data_o (out, DATA_W)
Bypass rule (combinational): rX_data_o = w_data_o if RegWrite_o=1 and w_addr_o==rX_addr_i and rX_addr_i!=0; otherwise rX_data_o = rX_rf_data_i. This makes read data reflect the committing write for the whole cycle.
When the macro is undefined, these ports and this logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_i mid-cycle while RegWrite_o=1 -> RegWrite_o=0 and b_age_o=0 immediately, before the next edge.
- Single A: a_valid_i=1, a_addr_i=3, a_data_i=0x12345678 -> a_ready_o=1 same cycle; next cycle RegWrite_o=1, w_addr_o=3, w_data_o=0x12345678.
- Tie, PRIO_MODE=1: A and B both valid for 4 cycles (with new data each transfer) -> grants A,B,A,B; RegWrite_o=1 for 4 consecutive cycles.
- Aging, PRIO_MODE=0, AGE_LIMIT=4: A and B continuously valid -> A granted 4 cycles, B granted in the 5th cycle (b_age_o=4), then b_age_o=0.
- r0 drop plus stall: B writes addr 0, data 0xFFFFFFFF -> b_ready_o=1, RegWrite_o stays 0. Then stall_i=1 with A valid -> a_ready_o=0 and b_age_o holds.
- WR_ARB_FWD_EN: A writes r7=0xCAFEF00D, r1_addr_i=7, r1_rf_data_i=0 -> r1_data_o=0xCAFEF00D during the commit cycle. With r1_addr_i=0 -> r1_data_o=r1_rf_data_i.
